// File: rtl/spi_slave_axis_egress_packer_if.sv
// AXI-Stream style handshake bundle used on both sides of the egress packer.
interface spi_slave_axis_egress_packer_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tlast;

   modport master (output tdata, output tvalid, output tlast, input  tready);
   modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/spi_slave_axis_egress_packer.sv
// Buffers one frame of wide words and replays it as header + payload bytes.
// Optional trailing XOR checksum byte: define SPI_EGRESS_PACKER_CHECKSUM_EN.
module spi_slave_axis_egress_packer #(
   parameter int         WORD_BYTES     = 4,
   parameter int         MTU_SIZE       = 16,
   parameter logic [3:0] HEADER_TAG     = 4'hA,
   parameter bit         MSB_BYTE_FIRST = 1'b0
) (
   input  logic                             spi_clk,
   input  logic                             res,
   spi_slave_axis_egress_packer_if.slave    s_axis,
   spi_slave_axis_egress_packer_if.master   m_axis,
   output logic                             busy
);

   localparam int DW = WORD_BYTES * 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_HEADER,
      ST_DATA
`ifdef SPI_EGRESS_PACKER_CHECKSUM_EN
      , ST_CHK
`endif
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [DW-1:0]   r_mem [MTU_SIZE];
   logic [4:0]      r_wcnt, w_wcnt_nxt;
   logic [2:0]      r_bidx, w_bidx_nxt;
   logic [3:0]      r_rptr, w_rptr_nxt;
   logic            r_s_tready, r_m_tvalid, r_m_tlast, r_busy;
   logic [7:0]      r_m_tdata;
   logic            w_s_tready_nxt, w_m_tvalid_nxt, w_m_tlast_nxt;
   logic [7:0]      w_m_tdata_nxt;
   logic            w_wr_en;
   logic [3:0]      w_wr_idx;
   logic            w_s_fire, w_m_fire, w_word_end, w_frame_end;
   logic [DW-1:0]   w_rd_word;
   logic [2:0]      w_sel;
   logic [7:0]      w_rd_byte;
`ifdef SPI_EGRESS_PACKER_CHECKSUM_EN
   logic [7:0]      r_chk, w_chk_nxt;
`endif

   assign w_s_fire    = s_axis.tvalid & r_s_tready;
   assign w_m_fire    = r_m_tvalid & m_axis.tready;
   assign w_word_end  = (r_bidx == 3'(WORD_BYTES - 1));
   assign w_frame_end = w_word_end && ({1'b0, r_rptr} == r_wcnt - 5'd1);

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_wcnt_nxt  = r_wcnt;
      w_bidx_nxt  = r_bidx;
      w_rptr_nxt  = r_rptr;
      w_wr_en     = 1'b0;
      w_wr_idx    = r_wcnt[3:0];
      case (r_state)
         ST_IDLE, ST_FILL: begin
            if (w_s_fire) begin
               w_wr_en    = 1'b1;
               w_wr_idx   = (r_state == ST_IDLE) ? 4'd0 : r_wcnt[3:0];
               w_wcnt_nxt = (r_state == ST_IDLE) ? 5'd1 : r_wcnt + 5'd1;
               if (s_axis.tlast || (w_wcnt_nxt == 5'(MTU_SIZE)))
                  w_state_nxt = ST_HEADER;
               else
                  w_state_nxt = ST_FILL;
            end
         end
         ST_HEADER: begin
            if (w_m_fire) begin
               w_state_nxt = ST_DATA;
               w_rptr_nxt  = 4'd0;
               w_bidx_nxt  = 3'd0;
            end
         end
         ST_DATA: begin
            if (w_m_fire) begin
               if (w_frame_end) begin
`ifdef SPI_EGRESS_PACKER_CHECKSUM_EN
                  w_state_nxt = ST_CHK;
`else
                  w_state_nxt = ST_IDLE;
`endif
               end else if (w_word_end) begin
                  w_bidx_nxt = 3'd0;
                  w_rptr_nxt = r_rptr + 4'd1;
               end else begin
                  w_bidx_nxt = r_bidx + 3'd1;
               end
            end
         end
`ifdef SPI_EGRESS_PACKER_CHECKSUM_EN
         ST_CHK: if (w_m_fire) w_state_nxt = ST_IDLE;
`endif
         default: w_state_nxt = ST_IDLE;
      endcase
   end

`ifdef SPI_EGRESS_PACKER_CHECKSUM_EN
   always_comb begin
      w_chk_nxt = r_chk;
      if (r_state == ST_IDLE)
         w_chk_nxt = 8'h00;
      else if (w_m_fire && (r_state == ST_HEADER || r_state == ST_DATA))
         w_chk_nxt = r_chk ^ r_m_tdata;
   end
`endif

   // Outputs are registered, so they are derived from the next-state values.
   always_comb begin
      w_sel     = MSB_BYTE_FIRST ? 3'(WORD_BYTES - 1) - w_bidx_nxt : w_bidx_nxt;
      w_rd_word = r_mem[w_rptr_nxt];
      w_rd_byte = 8'h00;
      for (int b = 0; b < WORD_BYTES; b++)
         if (w_sel == 3'(b)) w_rd_byte = w_rd_word[b*8 +: 8];
   end

   always_comb begin
      w_s_tready_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_FILL);
      // The header byte appears one cycle after the closing word is accepted.
      w_m_tvalid_nxt = (r_state == ST_HEADER) || (w_state_nxt == ST_DATA);
      w_m_tdata_nxt  = 8'h00;
      w_m_tlast_nxt  = 1'b0;
      case (w_state_nxt)
         ST_HEADER: w_m_tdata_nxt = {HEADER_TAG, 4'(w_wcnt_nxt - 5'd1)};
         ST_DATA: begin
            w_m_tdata_nxt = w_rd_byte;
`ifndef SPI_EGRESS_PACKER_CHECKSUM_EN
            w_m_tlast_nxt = (w_bidx_nxt == 3'(WORD_BYTES - 1)) &&
                            ({1'b0, w_rptr_nxt} == w_wcnt_nxt - 5'd1);
`endif
         end
`ifdef SPI_EGRESS_PACKER_CHECKSUM_EN
         ST_CHK: begin
            w_m_tvalid_nxt = 1'b1;
            w_m_tdata_nxt  = w_chk_nxt;
            w_m_tlast_nxt  = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge spi_clk or posedge res) begin
      if (res) begin
         r_state    <= ST_IDLE;
         r_wcnt     <= 5'd0;
         r_bidx     <= 3'd0;
         r_rptr     <= 4'd0;
         r_s_tready <= 1'b0;
         r_m_tvalid <= 1'b0;
         r_m_tdata  <= 8'h00;
         r_m_tlast  <= 1'b0;
         r_busy     <= 1'b0;
`ifdef SPI_EGRESS_PACKER_CHECKSUM_EN
         r_chk      <= 8'h00;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_wcnt     <= w_wcnt_nxt;
         r_bidx     <= w_bidx_nxt;
         r_rptr     <= w_rptr_nxt;
         r_s_tready <= w_s_tready_nxt;
         r_m_tvalid <= w_m_tvalid_nxt;
         r_m_tdata  <= w_m_tdata_nxt;
         r_m_tlast  <= w_m_tlast_nxt;
         r_busy     <= (w_state_nxt != ST_IDLE);
`ifdef SPI_EGRESS_PACKER_CHECKSUM_EN
         r_chk      <= w_chk_nxt;
`endif
      end
   end

   // NOTE: the word buffer is never reset; entries are always written before being read.
   always_ff @(posedge spi_clk) begin
      if (w_wr_en) r_mem[w_wr_idx] <= s_axis.tdata;
   end

   assign s_axis.tready = r_s_tready;
   assign m_axis.tvalid = r_m_tvalid;
   assign m_axis.tdata  = r_m_tdata;
   assign m_axis.tlast  = r_m_tlast;
   assign busy          = r_busy;

endmodule

// File: tb/tb_spi_slave_axis_egress_packer.sv
// Directed bench: a frame-level byte model feeds one per-cycle compare process.
module tb_spi_slave_axis_egress_packer;

   localparam int         WB        = 4;
   localparam int         MTU       = 16;
   localparam logic [3:0] TAG       = 4'hA;
   localparam bit         MSB_FIRST = 1'b0;
`ifdef SPI_EGRESS_PACKER_CHECKSUM_EN
   localparam bit         CHK_EN    = 1'b1;
`else
   localparam bit         CHK_EN    = 1'b0;
`endif

   logic spi_clk = 1'b0;
   logic res     = 1'b0;
   logic busy;

   spi_slave_axis_egress_packer_if #(.DATA_W(WB*8)) s_axis ();
   spi_slave_axis_egress_packer_if #(.DATA_W(8))    m_axis ();

   spi_slave_axis_egress_packer #(
      .WORD_BYTES     (WB),
      .MTU_SIZE       (MTU),
      .HEADER_TAG     (TAG),
      .MSB_BYTE_FIRST (MSB_FIRST)
   ) dut (
      .spi_clk (spi_clk),
      .res     (res),
      .s_axis  (s_axis),
      .m_axis  (m_axis),
      .busy    (busy)
   );

   always #5 spi_clk = ~spi_clk;

   int checks = 0;
   int errors = 0;

   logic [7:0]  exp_data[$];
   bit          exp_last[$];
   logic [7:0]  got_data[$];
   bit          got_last[$];
   logic [31:0] model_words[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // Expands the collected words into the byte sequence the frame must produce.
   function automatic void model_close();
      int         n = model_words.size();
      logic [7:0] b;
      logic [7:0] x;
      b = {TAG, 4'(n - 1)};
      x = b;
      exp_data.push_back(b);
      exp_last.push_back(1'b0);
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < WB; k++) begin
            int pos = MSB_FIRST ? (WB - 1 - k) : k;
            b = 8'((model_words[i] >> (8 * pos)) & 32'hFF);
            x ^= b;
            exp_data.push_back(b);
            exp_last.push_back(!CHK_EN && (i == n - 1) && (k == WB - 1));
         end
      end
      if (CHK_EN) begin
         exp_data.push_back(x);
         exp_last.push_back(1'b1);
      end
      model_words.delete();
   endfunction

   // Downstream ready: always high, or the repeating 1,0,0,1 pattern.
   int rdy_mode = 0;
   int rdy_cyc  = 0;
   bit pat [4]  = '{1'b1, 1'b0, 1'b0, 1'b1};

   always @(posedge spi_clk) begin
      #1;
      rdy_cyc++;
      m_axis.tready = (rdy_mode == 0) ? 1'b1 : pat[rdy_cyc % 4];
   end

   logic       prev_stall = 1'b0;
   logic [7:0] prev_data  = 8'h00;
   logic       prev_last  = 1'b0;

   always @(negedge spi_clk) begin
      if (res) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", 32'(m_axis.tvalid), 32'd1);
            check("stall_data",  32'(m_axis.tdata),  32'(prev_data));
            check("stall_last",  32'(m_axis.tlast),  32'(prev_last));
         end
         if (m_axis.tvalid) check("no_overlap", 32'(s_axis.tready), 32'd0);
         if (m_axis.tvalid && m_axis.tready) begin
            got_data.push_back(m_axis.tdata);
            got_last.push_back(m_axis.tlast);
            check("byte_expected", 32'(exp_data.size() != 0), 32'd1);
            if (exp_data.size() != 0) begin
               check("out_data", 32'(m_axis.tdata), 32'(exp_data.pop_front()));
               check("out_last", 32'(m_axis.tlast), 32'(exp_last.pop_front()));
            end
         end
         prev_stall = m_axis.tvalid && !m_axis.tready;
         prev_data  = m_axis.tdata;
         prev_last  = m_axis.tlast;
      end
   end

   task automatic send_frame(input int n, input bit use_last,
                             input logic [31:0] base, input logic [31:0] step);
      logic [31:0] w = base;
      for (int i = 0; i < n; i++) begin
         int k = 0;
         s_axis.tvalid = 1'b1;
         s_axis.tdata  = w;
         s_axis.tlast  = use_last && (i == n - 1);
         @(negedge spi_clk);
         while (!s_axis.tready && k < 200) begin
            @(negedge spi_clk);
            k++;
         end
         if (!s_axis.tready) begin
            check("accept_ready", 32'(s_axis.tready), 32'd1);
            s_axis.tvalid = 1'b0;
            return;
         end
         @(posedge spi_clk);
         #1;
         model_words.push_back(w);
         if (s_axis.tlast || model_words.size() == MTU) begin
            model_close();
            check("close_tready", 32'(s_axis.tready), 32'd0);
         end
         w += step;
      end
      s_axis.tvalid = 1'b0;
      s_axis.tlast  = 1'b0;
   endtask

   task automatic wait_drain();
      int k = 0;
      while (exp_data.size() != 0 && k < 600) begin
         @(negedge spi_clk);
         #1;
         k++;
      end
      check("drain_left", 32'(exp_data.size()), 32'd0);
      @(posedge spi_clk);
      #1;
      check("idle_tready", 32'(s_axis.tready), 32'd1);
      check("idle_tvalid", 32'(m_axis.tvalid), 32'd0);
      check("idle_busy",   32'(busy),          32'd0);
   endtask

   initial begin
      int         start;
      int         k;
      int         nlit;
      logic [31:0] word;
      logic [7:0] lit [6];

      s_axis.tvalid = 1'b0;
      s_axis.tdata  = '0;
      s_axis.tlast  = 1'b0;

      // Reset values and release timing.
      #1 res = 1'b1;
      #1;
      check("rst_s_tready", 32'(s_axis.tready), 32'd0);
      check("rst_m_tvalid", 32'(m_axis.tvalid), 32'd0);
      check("rst_m_tdata",  32'(m_axis.tdata),  32'h00);
      check("rst_m_tlast",  32'(m_axis.tlast),  32'd0);
      check("rst_busy",     32'(busy),          32'd0);
      repeat (3) @(posedge spi_clk);
      #1 res = 1'b0;
      check("rel_tready_before", 32'(s_axis.tready), 32'd0);
      @(posedge spi_clk);
      #1;
      check("rel_tready_after", 32'(s_axis.tready), 32'd1);
      check("rel_busy",         32'(busy),          32'd0);

      // Single word with hand-computed byte sequence.
`ifdef SPI_EGRESS_PACKER_CHECKSUM_EN
      word = 32'h04030201;
      lit  = '{8'hA0, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA4};
      nlit = 6;
`else
      word = 32'h44332211;
      lit  = '{8'hA0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
      nlit = 5;
`endif
      start = got_data.size();
      send_frame(1, 1'b1, word, 32'h0);
      check("lat_tvalid_n",  32'(m_axis.tvalid), 32'd0);
      check("lat_busy_n",    32'(busy),          32'd1);
      @(posedge spi_clk);
      #1;
      check("lat_tvalid_n1", 32'(m_axis.tvalid), 32'd1);
      check("lat_hdr_n1",    32'(m_axis.tdata),  32'hA0);
      wait_drain();
      check("single_len", 32'(got_data.size() - start), 32'(nlit));
      for (int i = 0; i < nlit; i++)
         check("single_byte", 32'(got_data[start + i]), 32'(lit[i]));
      check("single_last",     32'(got_last[start + nlit - 1]), 32'd1);
      check("single_not_last", 32'(got_last[start + nlit - 2]), 32'd0);

      // Frame closed by MTU without tlast.
      start = got_data.size();
      send_frame(MTU, 1'b0, 32'h03020100, 32'h04040404);
      wait_drain();
      check("mtu_header", 32'(got_data[start]), 32'hAF);
      check("mtu_len", 32'(got_data.size() - start), 32'(1 + MTU*WB + (CHK_EN ? 1 : 0)));

      // Backpressure on a 2-word frame.
      rdy_mode = 1;
      start = got_data.size();
      send_frame(2, 1'b1, 32'h88776655, 32'h11111111);
      wait_drain();
      rdy_mode = 0;
      check("bp_len", 32'(got_data.size() - start), 32'(9 + (CHK_EN ? 1 : 0)));
      check("bp_header", 32'(got_data[start]), 32'hA1);

      // Reset in the middle of a 3-word frame's payload.
      start = got_data.size();
      send_frame(3, 1'b1, 32'h30201000, 32'h01010101);
      k = 0;
      while (got_data.size() < start + 3 && k < 200) begin
         @(negedge spi_clk);
         #1;
         k++;
      end
      check("mid_progress", 32'(got_data.size() >= start + 3), 32'd1);
      res = 1'b1;
      #1;
      check("mid_tvalid", 32'(m_axis.tvalid), 32'd0);
      check("mid_tready", 32'(s_axis.tready), 32'd0);
      check("mid_busy",   32'(busy),          32'd0);
      exp_data.delete();
      exp_last.delete();
      model_words.delete();
      @(posedge spi_clk);
      #1 res = 1'b0;
      @(posedge spi_clk);
      #1;
      check("mid_rel_tready", 32'(s_axis.tready), 32'd1);
      start = got_data.size();
      send_frame(1, 1'b1, 32'hDDCCBBAA, 32'h0);
      wait_drain();
      check("post_rst_hdr",   32'(got_data[start]),     32'hA0);
      check("post_rst_byte0", 32'(got_data[start + 1]), 32'hAA);
      check("post_rst_byte3", 32'(got_data[start + 4]), 32'hDD);

      check("final_queue", 32'(exp_data.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
